// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low abcdefg glyphs and sample layout.
// Both the display driver and the capture side use this table.
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    localparam logic [0:6] SEG_0     = 7'b0000001;
    localparam logic [0:6] SEG_1     = 7'b1001111;
    localparam logic [0:6] SEG_2     = 7'b0010010;
    localparam logic [0:6] SEG_3     = 7'b0000110;
    localparam logic [0:6] SEG_4     = 7'b1001100;
    localparam logic [0:6] SEG_5     = 7'b0100100;
    localparam logic [0:6] SEG_6     = 7'b0100000;
    localparam logic [0:6] SEG_7     = 7'b0001111;
    localparam logic [0:6] SEG_8     = 7'b0000000;
    localparam logic [0:6] SEG_9     = 7'b0000100;
    localparam logic [0:6] SEG_BLANK = 7'b1111111;

    typedef struct packed {
        logic [3:0] an;
        logic [0:6] seg;
    } sample_t;

    localparam sample_t SAMPLE_RST = '{an: 4'b1111, seg: SEG_BLANK};

    function automatic logic [0:6] seg7_glyph(input logic [3:0] bcd);
        logic [0:6] g;
        unique case (bcd)
            4'd0:    g = SEG_0;
            4'd1:    g = SEG_1;
            4'd2:    g = SEG_2;
            4'd3:    g = SEG_3;
            4'd4:    g = SEG_4;
            4'd5:    g = SEG_5;
            4'd6:    g = SEG_6;
            4'd7:    g = SEG_7;
            4'd8:    g = SEG_8;
            4'd9:    g = SEG_9;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Active-low abcdefg pattern to BCD, flagging blank and non-glyph patterns.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [0:6] seg_i,
    output logic       is_glyph_o,
    output logic       is_blank_o,
    output logic [3:0] bcd_o
);

    always_comb begin
        is_glyph_o = 1'b1;
        is_blank_o = 1'b0;
        bcd_o      = 4'd0;
        unique case (seg_i)
            SEG_0: bcd_o = 4'd0;
            SEG_1: bcd_o = 4'd1;
            SEG_2: bcd_o = 4'd2;
            SEG_3: bcd_o = 4'd3;
            SEG_4: bcd_o = 4'd4;
            SEG_5: bcd_o = 4'd5;
            SEG_6: bcd_o = 4'd6;
            SEG_7: bcd_o = 4'd7;
            SEG_8: bcd_o = 4'd8;
            SEG_9: bcd_o = 4'd9;
            SEG_BLANK: begin
                is_glyph_o = 1'b0;
                is_blank_o = 1'b1;
            end
            default: is_glyph_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// Seven-segment bus sniffer: waits for a stable {an,SSeg} sample and
// decodes it back into a per-anode BCD digit with valid/error flags.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [0:6]  SSeg,
    input  logic [3:0]  an,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic [3:0]  err,
    output logic        upd,
    output logic [1:0]  upd_idx
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    sample_t          in_q, in_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      digits_q, digits_d;
    logic [3:0]       valid_q, valid_d;
    logic [3:0]       err_q, err_d;
    logic             upd_q, upd_d;
    logic [1:0]       idx_q, idx_d;

    logic       same, fire;
    logic       sel_ok;
    logic [1:0] sel_idx;
    logic       is_glyph, is_blank;
    logic [3:0] bcd;

    seg7_pattern_decode u_dec (
        .seg_i      (in_q.seg),
        .is_glyph_o (is_glyph),
        .is_blank_o (is_blank),
        .bcd_o      (bcd)
    );

    assign same = (in_q == in_prev_q);

    // Fire only on the step into STABLE_CYCLES, never while parked there.
    always_comb begin
        if (same) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        end else begin
            cnt_d = CNT_ONE;
        end
        fire = (cnt_d == CNT_MAX) && (!same || cnt_q != CNT_MAX);
    end

    always_comb begin
        sel_ok  = 1'b1;
        sel_idx = 2'd0;
        unique case (in_q.an)
            4'b1110: sel_idx = 2'd0;
            4'b1101: sel_idx = 2'd1;
            4'b1011: sel_idx = 2'd2;
            4'b0111: sel_idx = 2'd3;
            default: sel_ok  = 1'b0;
        endcase
    end

    always_comb begin
        digits_d = digits_q;
        valid_d  = valid_q;
        err_d    = err_q;
        upd_d    = 1'b0;
        idx_d    = idx_q;
        if (fire && sel_ok) begin
            upd_d = 1'b1;
            idx_d = sel_idx;
            if (is_glyph) begin
                digits_d[{sel_idx, 2'b00} +: 4] = bcd;
                valid_d[sel_idx] = 1'b1;
                err_d[sel_idx]   = 1'b0;
            end else if (is_blank) begin
                valid_d[sel_idx] = 1'b0;
                err_d[sel_idx]   = 1'b0;
            end else begin
                err_d[sel_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q      <= SAMPLE_RST;
            in_prev_q <= SAMPLE_RST;
            cnt_q     <= '0;
            digits_q  <= '0;
            valid_q   <= '0;
            err_q     <= '0;
            upd_q     <= 1'b0;
            idx_q     <= 2'd0;
        end else begin
            in_q      <= '{an: an, seg: SSeg};
            in_prev_q <= in_q;
            cnt_q     <= cnt_d;
            digits_q  <= digits_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            upd_q     <= upd_d;
            idx_q     <= idx_d;
        end
    end

    assign digits      = digits_q;
    assign digit_valid = valid_q;
    assign err         = err_q;
    assign upd         = upd_q;
    assign upd_idx     = idx_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: drives anode/segment dwells and checks each
// capture pulse against a queue of expected results and timing.
module tb_seg7_capture;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [0:6]  SSeg = 7'b1111111;
    logic [3:0]  an = 4'b1111;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic [3:0]  err;
    logic        upd;
    logic [1:0]  upd_idx;

    seg7_capture #(.STABLE_CYCLES(S), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .SSeg        (SSeg),
        .an          (an),
        .digits      (digits),
        .digit_valid (digit_valid),
        .err         (err),
        .upd         (upd),
        .upd_idx     (upd_idx)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        int          at;
        logic [1:0]  idx;
        logic [15:0] dg;
        logic [3:0]  v;
        logic [3:0]  e;
    } exp_t;

    exp_t        sbq[$];
    logic [15:0] m_dg = '0;
    logic [3:0]  m_v = '0;
    logic [3:0]  m_e = '0;
    int          total = 0;
    int          bad = 0;

    logic [6:0] glyphs [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic int an_idx(input logic [3:0] a);
        case (a)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic push(input logic [3:0] a, input logic [6:0] s);
        exp_t x;
        int   idx;
        int   val;
        idx = an_idx(a);
        val = -1;
        for (int i = 0; i < 10; i++) if (glyphs[i] == s) val = i;
        if (val >= 0) begin
            m_dg[idx*4 +: 4] = 4'(val);
            m_v[idx] = 1'b1;
            m_e[idx] = 1'b0;
        end else if (s == 7'b1111111) begin
            m_v[idx] = 1'b0;
            m_e[idx] = 1'b0;
        end else begin
            m_e[idx] = 1'b1;
        end
        x.at  = edge_n + 1 + S;
        x.idx = 2'(idx);
        x.dg  = m_dg;
        x.v   = m_v;
        x.e   = m_e;
        sbq.push_back(x);
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] s,
                         input int n);
        @(negedge clk);
        an   = a;
        SSeg = s;
        if (n >= S && an_idx(a) >= 0) push(a, s);
        repeat (n - 1) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n && upd) begin
            if (sbq.size() == 0) begin
                chk("no_upd", 32'(upd), 32'd0);
            end else begin
                exp_t x;
                x = sbq.pop_front();
                chk("upd_at", 32'(edge_n), 32'(x.at));
                chk("upd_idx", 32'(upd_idx), 32'(x.idx));
                chk("digits", 32'(digits), 32'(x.dg));
                chk("valid", 32'(digit_valid), 32'(x.v));
                chk("err", 32'(err), 32'(x.e));
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_digits", 32'(digits), 32'd0);
        chk("rst_valid", 32'(digit_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_upd", 32'(upd), 32'd0);
        chk("rst_idx", 32'(upd_idx), 32'd0);
        rst_n = 1'b1;

        drive(4'b1110, 7'b0010010, 6);

        drive(4'b1110, 7'b1001111, 6);
        drive(4'b1101, 7'b0000100, 6);
        drive(4'b1011, 7'b0000001, 6);
        drive(4'b0111, 7'b0001111, 6);
        chk("scan_digits", 32'(digits), 32'h7091);
        chk("scan_valid", 32'(digit_valid), 32'hF);

        for (int i = 0; i < 4; i++) begin
            drive(4'b1101, 7'b0010010, 2);
            drive(4'b1101, 7'b0100100, 2);
        end
        drive(4'b1101, 7'b0000000, S - 1);
        chk("toggle_digits", 32'(digits), 32'h7091);
        drive(4'b1101, 7'b1001100, 6);
        chk("digit1_is_4", 32'(digits[7:4]), 32'd4);

        drive(4'b1011, 7'b1110000, 6);
        chk("illegal_err", 32'(err), 32'b0100);
        chk("illegal_valid", 32'(digit_valid), 32'hF);
        drive(4'b1011, 7'b1111111, 6);
        chk("blank_err", 32'(err), 32'd0);
        chk("blank_valid", 32'(digit_valid), 32'b1011);

        drive(4'b1111, 7'b0000000, 10);
        drive(4'b1100, 7'b0000000, 10);
        chk("unq_digits", 32'(digits), 32'(m_dg));
        chk("unq_valid", 32'(digit_valid), 32'(m_v));
        chk("unq_err", 32'(err), 32'(m_e));

        drive(4'b0111, 7'b0000110, 2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_digits", 32'(digits), 32'd0);
        chk("mid_rst_valid", 32'(digit_valid), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_upd", 32'(upd), 32'd0);
        m_dg = '0;
        m_v  = '0;
        m_e  = '0;
        sbq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push(4'b0111, 7'b0000110);
        repeat (S + 3) @(negedge clk);
        chk("post_rst_digits", 32'(digits), 32'h3000);
        chk("post_rst_valid", 32'(digit_valid), 32'b1000);
        chk("pending", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
